sap_microsequencer: RTL and testbench
=====================================

// Module: sap_microsequencer
// PURPOSE
//  Parametrised SAP control unit: a T-state ring counter plus a microcode ROM that drives
//  the datapath control word. Ends each instruction early when its END bit is set.
//  Supports conditional jumps on carry/zero flags, a sticky halt, and a single-step mode.
//  Sits between the instruction register (OPC) / flags register and all bus enables.
// PARAMETERS
//  OPC_W    4   opcode width (ROM depth 2**OPC_W)
//  CW_W     14  control word width; default {CE,CO,MI,RO,II,IO,AI,AO,SU,EO,BI,OI,J,FI}, CE=[13], FI=[0]
//  T_STATES 6   T-states per instruction, legal range FETCH_T+1..8
//  FETCH_T  3   common fetch steps T0..T(FETCH_T-1); opcode-independent
// PORTS
//  CLK        in   1         system clock; T state advances on the falling edge
//  RST        in   1         async active-high reset
//  OPC        in   OPC_W     opcode from IR; valid from T(FETCH_T) onward
//  CF         in   1         carry flag
//  ZF         in   1         zero flag
//  STEP_MODE  in   1         1 = pause after every instruction
//  STEP       in   1         step request; rising edge detected on falling CLK
//  HLT        out  1         halted (sticky until RST)
//  COUT       out  CW_W      control word for current T state
//  TSTATE     out  T_STATES  one-hot current T state (display)
//  INSTR_DONE out  1         high during the last T state of an instruction
// BEHAVIOUR
//  - Reset (async): T=T0, HLT=0, step latch cleared; COUT=0, TSTATE=0, INSTR_DONE=0 while RST=1.
//  - After reset release: COUT decodes (T, OPC, CF, ZF) combinationally.
//  - T advances on negedge CLK. The datapath samples COUT on posedge.
//  - Fetch (default): T0 CO|MI; T1 CE; T2 RO|II.
//  - Execute (opcode 4'hX, steps from T3):
//      NOP 0: T3 END
//      LDA 1: T3 IO|MI; T4 RO|AI END
//      ADD 2: T3 IO|MI; T4 RO|BI; T5 EO|AI|FI END
//      SUB 3: T3 IO|MI; T4 RO|BI; T5 EO|SU|AI|FI END
//      JMP 6: T3 IO|J END
//      JC  7: T3 (CF ? IO|J : 0) END
//      JZ  8: T3 (ZF ? IO|J : 0) END
//      OUT E: T3 AO|OI END
//      HLT F: T3 END, sets HLT
//      all other opcodes decode as NOP.
//  - Step sequencing:
//      * END step: next T=T0 and INSTR_DONE=1 during it.
//      * Last T state (T_STATES-1) always forces END, even if the ROM does not.
//      * Otherwise T increments.
//      * Wrap-around never exceeds T_STATES-1.
//  - Halt: HLT is set on the falling edge that leaves T3 of HLT.
//      * T then freezes at T0, COUT=0, TSTATE=0.
//      * Only RST clears it. STEP is ignored while halted.
//  - Single step (STEP_MODE=1): after an END step, sequencer enters WAIT.
//      * WAIT: COUT=0, TSTATE=0.
//      * Exits to T0 on the first STEP rising edge.
//      * STEP edge captured in WAIT is consumed. Edges outside WAIT are discarded.
//      * STEP_MODE dropping to 0 in WAIT exits to T0 on the next falling edge.
//  - STEP_MODE change mid-instruction takes effect at the next END.
//  - RST mid-instruction aborts immediately; no partial control word persists.
//  - FSM states: RUN(T0..Tn), WAIT, HALT. Transitions occur only on negedge CLK or RST.
// STRUCTURE
//  - Package sap_pkg: opcode localparams (OP_NOP..OP_HLT), control bit indices (CE_B..FI_B),
//    CW_W default, END bit position.
//  - Sub-module sap_microcode_rom (combinational).
//      * In: {OPC, T index, CF, ZF}.
//      * Out: {END, HLT_REQ, COUT}.
//  - Top holds the T counter, the WAIT/HALT FSM, the STEP edge detector and the reset gating.
// TESTING
//  - Reset:
//      * Assert RST mid-T4 of ADD -> COUT=0 immediately.
//      * Release -> T0 with COUT=CO|MI (14'h1800).
//  - LDA (OPC=1):
//      * COUT sequence CO|MI, CE, RO|II, IO|MI, RO|AI.
//      * INSTR_DONE at T4; next T0 follows T4, not T5.
//  - JC:
//      * OPC=7, CF=1 -> T3 COUT=IO|J.
//      * CF=0 -> T3 COUT=0 with END; next T0.
//  - HLT (OPC=F):
//      * HLT=1 after T3; COUT=0 and TSTATE=0 for 20 clocks.
//      * STEP pulses ignored; RST clears.
//  - Single step (STEP_MODE=1, OUT):
//      * After T3, WAIT holds COUT=0 for 10 clocks.
//      * STEP pulse -> T0 on next falling edge; a STEP held high does not retrigger.
//  - Parameter sweep:
//      * T_STATES=8, FETCH_T=3.
//      * Opcode with no END -> forced END at T7, wrap to T0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP microsequencer: opcodes, control-word bit
// positions, ROM word layout and the sequencer state type.
package sap_pkg;

  localparam int CW_W_DEF = 14;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JC  = 7;
  localparam int unsigned OP_JZ  = 8;
  localparam int unsigned OP_OUT = 14;
  localparam int unsigned OP_HLT = 15;

  localparam int unsigned CE_B = 13;
  localparam int unsigned CO_B = 12;
  localparam int unsigned MI_B = 11;
  localparam int unsigned RO_B = 10;
  localparam int unsigned II_B = 9;
  localparam int unsigned IO_B = 8;
  localparam int unsigned AI_B = 7;
  localparam int unsigned AO_B = 6;
  localparam int unsigned SU_B = 5;
  localparam int unsigned EO_B = 4;
  localparam int unsigned BI_B = 3;
  localparam int unsigned OI_B = 2;
  localparam int unsigned J_B  = 1;
  localparam int unsigned FI_B = 0;

  // ROM word = {END, HLT_REQ, control word}; offsets are above the control word
  localparam int END_OFS = 1;
  localparam int HLT_OFS = 0;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/sap_microsequencer_if.sv
// Bus between the microsequencer and its datapath: opcode/flags/step controls in,
// control word and status out.
interface sap_microsequencer_if import sap_pkg::*; #(
  parameter int OPC_W    = 4,
  parameter int CW_W     = CW_W_DEF,
  parameter int T_STATES = 6
) ();

  logic [OPC_W-1:0]    opc;
  logic                cf;
  logic                zf;
  logic                step_mode;
  logic                step;
  logic                hlt;
  logic [CW_W-1:0]     cout;
  logic [T_STATES-1:0] tstate;
  logic                instr_done;

  modport master (
    input  opc, cf, zf, step_mode, step,
    output hlt, cout, tstate, instr_done
  );

  modport slave (
    output opc, cf, zf, step_mode, step,
    input  hlt, cout, tstate, instr_done
  );

endinterface

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: maps {opcode, T index, CF, ZF} to {END, HLT_REQ, control word}.
module sap_microcode_rom import sap_pkg::*; #(
  parameter int OPC_W   = 4,
  parameter int CW_W    = CW_W_DEF,
  parameter int T_W     = 3,
  parameter int FETCH_T = 3
) (
  input  logic [OPC_W-1:0] opc,
  input  logic [T_W-1:0]   t,
  input  logic             cf,
  input  logic             zf,
  output logic [CW_W+1:0]  word
);

  localparam int unsigned FT = unsigned'(FETCH_T);

  int unsigned     ti;
  int unsigned     op;
  int unsigned     e;
  logic [CW_W-1:0] cw;
  logic            fin;
  logic            hreq;

  always_comb begin
    ti   = 32'(t);
    op   = 32'(opc);
    e    = ti - FT;
    cw   = '0;
    fin  = 1'b0;
    hreq = 1'b0;
    if (ti < FT) begin
      case (ti)
        0: begin cw[CO_B] = 1'b1; cw[MI_B] = 1'b1; end
        1: cw[CE_B] = 1'b1;
        2: begin cw[RO_B] = 1'b1; cw[II_B] = 1'b1; end
        default: ;
      endcase
    end else begin
      case (op)
        OP_LDA: begin
          if (e == 0) begin cw[IO_B] = 1'b1; cw[MI_B] = 1'b1; end
          if (e == 1) begin cw[RO_B] = 1'b1; cw[AI_B] = 1'b1; fin = 1'b1; end
        end
        OP_ADD, OP_SUB: begin
          if (e == 0) begin cw[IO_B] = 1'b1; cw[MI_B] = 1'b1; end
          if (e == 1) begin cw[RO_B] = 1'b1; cw[BI_B] = 1'b1; end
          if (e == 2) begin
            cw[EO_B] = 1'b1;
            cw[AI_B] = 1'b1;
            cw[FI_B] = 1'b1;
            cw[SU_B] = (op == OP_SUB);
            fin      = 1'b1;
          end
        end
        OP_JMP: if (e == 0) begin cw[IO_B] = 1'b1; cw[J_B] = 1'b1; fin = 1'b1; end
        OP_JC:  if (e == 0) begin cw[IO_B] = cf; cw[J_B] = cf; fin = 1'b1; end
        OP_JZ:  if (e == 0) begin cw[IO_B] = zf; cw[J_B] = zf; fin = 1'b1; end
        OP_OUT: if (e == 0) begin cw[AO_B] = 1'b1; cw[OI_B] = 1'b1; fin = 1'b1; end
        OP_HLT: if (e == 0) begin fin = 1'b1; hreq = 1'b1; end
        OP_NOP: if (e == 0) fin = 1'b1;
        default: if (e == 0) fin = 1'b1;
      endcase
    end
    word                  = '0;
    word[CW_W-1:0]        = cw;
    word[CW_W + END_OFS]  = fin;
    word[CW_W + HLT_OFS]  = hreq;
  end

endmodule

// File: rtl/sap_microsequencer.sv
// SAP control unit: falling-edge T-state sequencer with early END, sticky halt and
// single-step WAIT, driving the control word decoded by the microcode ROM.
module sap_microsequencer import sap_pkg::*; #(
  parameter int OPC_W    = 4,
  parameter int CW_W     = CW_W_DEF,
  parameter int T_STATES = 6,
  parameter int FETCH_T  = 3
) (
  input logic                 clk,
  input logic                 rst,
  sap_microsequencer_if.master bus
);

  localparam int T_W = $clog2(T_STATES);
  localparam logic [T_W-1:0] T_LAST = T_W'(T_STATES - 1);

  seq_state_t      state;
  logic [T_W-1:0]  t;
  logic            step_q;
  logic            hlt_q;
  logic [CW_W+1:0] rom_word;
  logic            last_step;
  logic            running;

  sap_microcode_rom #(
    .OPC_W   (OPC_W),
    .CW_W    (CW_W),
    .T_W     (T_W),
    .FETCH_T (FETCH_T)
  ) u_rom (
    .opc  (bus.opc),
    .t    (t),
    .cf   (bus.cf),
    .zf   (bus.zf),
    .word (rom_word)
  );

  always_comb begin
    last_step      = rom_word[CW_W + END_OFS] || (t == T_LAST);
    // Outputs are gated by rst itself so the reset window shows no control word.
    running        = (state == S_RUN) && !rst;
    bus.cout       = running ? rom_word[CW_W-1:0] : '0;
    bus.tstate     = running ? (T_STATES'(1) << t) : '0;
    bus.instr_done = running && last_step;
    bus.hlt        = hlt_q;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RUN;
      t      <= '0;
      step_q <= 1'b0;
      hlt_q  <= 1'b0;
    end else begin
      step_q <= bus.step;
      case (state)
        S_RUN: begin
          if (last_step) begin
            t <= '0;
            if (rom_word[CW_W + HLT_OFS]) begin
              state <= S_HALT;
              hlt_q <= 1'b1;
            end else if (bus.step_mode) begin
              state <= S_WAIT;
            end
          end else begin
            t <= t + T_W'(1);
          end
        end
        S_WAIT: if (!bus.step_mode || (bus.step && !step_q)) state <= S_RUN;
        S_HALT: ;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_microsequencer.sv
// Bench for sap_microsequencer: three parameterisations driven in lockstep and checked
// every cycle against an instruction-level model, plus directed literal checks.
module tb_sap_microsequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opc;
  logic       cf, zf, step_mode, step;

  always #5 clk = ~clk;

  sap_microsequencer_if #(.OPC_W(4), .CW_W(14), .T_STATES(6)) if0 ();
  sap_microsequencer_if #(.OPC_W(4), .CW_W(14), .T_STATES(8)) if1 ();
  sap_microsequencer_if #(.OPC_W(4), .CW_W(14), .T_STATES(4)) if2 ();

  assign if0.opc = opc; assign if0.cf = cf; assign if0.zf = zf;
  assign if0.step_mode = step_mode; assign if0.step = step;
  assign if1.opc = opc; assign if1.cf = cf; assign if1.zf = zf;
  assign if1.step_mode = step_mode; assign if1.step = step;
  assign if2.opc = opc; assign if2.cf = cf; assign if2.zf = zf;
  assign if2.step_mode = step_mode; assign if2.step = step;

  sap_microsequencer #(.OPC_W(4), .CW_W(14), .T_STATES(6), .FETCH_T(3)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  sap_microsequencer #(.OPC_W(4), .CW_W(14), .T_STATES(8), .FETCH_T(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  sap_microsequencer #(.OPC_W(4), .CW_W(14), .T_STATES(4), .FETCH_T(3)) dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  logic [13:0] a_cout [3];
  logic [7:0]  a_ts   [3];
  logic        a_done [3];
  logic        a_hlt  [3];

  assign a_cout[0] = if0.cout; assign a_ts[0] = {2'b00, if0.tstate};
  assign a_cout[1] = if1.cout; assign a_ts[1] = if1.tstate;
  assign a_cout[2] = if2.cout; assign a_ts[2] = {4'h0, if2.tstate};
  assign a_done[0] = if0.instr_done; assign a_hlt[0] = if0.hlt;
  assign a_done[1] = if1.instr_done; assign a_hlt[1] = if1.hlt;
  assign a_done[2] = if2.instr_done; assign a_hlt[2] = if2.hlt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: each opcode is a list of execute words after the fixed fetch.
  int          ts_of [3] = '{6, 8, 4};
  logic [13:0] ex_tab [16][3];
  int          ex_len [16];
  int          m_mode [3];   // 0 running, 1 waiting for step, 2 halted
  int          m_t    [3];
  bit          m_prev [3];

  initial begin
    for (int op = 0; op < 16; op++) begin
      ex_len[op] = 1;
      for (int s = 0; s < 3; s++) ex_tab[op][s] = 14'h0;
    end
    ex_len[1] = 2; ex_tab[1][0] = 14'h0900; ex_tab[1][1] = 14'h0480;
    ex_len[2] = 3; ex_tab[2][0] = 14'h0900; ex_tab[2][1] = 14'h0408; ex_tab[2][2] = 14'h0091;
    ex_len[3] = 3; ex_tab[3][0] = 14'h0900; ex_tab[3][1] = 14'h0408; ex_tab[3][2] = 14'h00B1;
    ex_tab[6][0]  = 14'h0102;
    ex_tab[7][0]  = 14'h0102;
    ex_tab[8][0]  = 14'h0102;
    ex_tab[14][0] = 14'h0044;
  end

  function automatic logic [13:0] exp_word(input int op, input int t, input bit c, input bit z);
    if (t == 0) return 14'h1800;
    if (t == 1) return 14'h2000;
    if (t == 2) return 14'h0600;
    if (t - 3 >= ex_len[op]) return 14'h0;
    if ((op == 7 && !c) || (op == 8 && !z)) return 14'h0;
    return ex_tab[op][t-3];
  endfunction

  function automatic bit natural_end(input int op, input int t);
    return t == 2 + ex_len[op];
  endfunction

  function automatic bit is_last(input int k, input int op, input int t);
    return natural_end(op, t) || (t == ts_of[k] - 1);
  endfunction

  initial begin
    bit run;
    bit rise;
    int op;
    for (int k = 0; k < 3; k++) begin m_mode[k] = 0; m_t[k] = 0; m_prev[k] = 1'b0; end
    forever begin
      @(negedge clk);
      op = int'(opc);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_mode[k] = 0; m_t[k] = 0; m_prev[k] = 1'b0;
        end else begin
          rise      = step && !m_prev[k];
          m_prev[k] = step;
          if (m_mode[k] == 0) begin
            if (is_last(k, op, m_t[k])) begin
              if (op == 15 && natural_end(op, m_t[k])) m_mode[k] = 2;
              else if (step_mode) m_mode[k] = 1;
              m_t[k] = 0;
            end else begin
              m_t[k] = m_t[k] + 1;
            end
          end else if (m_mode[k] == 1) begin
            if (!step_mode || rise) m_mode[k] = 0;
          end
        end
      end
      #2;
      op = int'(opc);
      for (int k = 0; k < 3; k++) begin
        run = (m_mode[k] == 0) && !rst;
        chk($sformatf("cout%0d", k), 32'(a_cout[k]),
            run ? 32'(exp_word(op, m_t[k], cf, zf)) : 32'd0);
        chk($sformatf("tstate%0d", k), 32'(a_ts[k]), run ? (32'd1 << m_t[k]) : 32'd0);
        chk($sformatf("done%0d", k), 32'(a_done[k]), 32'(run && is_last(k, op, m_t[k])));
        chk($sformatf("hlt%0d", k), 32'(a_hlt[k]), 32'(!rst && m_mode[k] == 2));
      end
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #2;
  endtask

  logic [13:0] lda_w [4] = '{14'h2000, 14'h0600, 14'h0900, 14'h0480};

  initial begin
    rst = 1'b1; opc = 4'h1; cf = 1'b0; zf = 1'b0; step_mode = 1'b0; step = 1'b0;
    at_pos(); at_pos();
    chk("rst_cout", 32'(a_cout[0]), 32'd0);
    chk("rst_tstate", 32'(a_ts[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_t0", 32'(a_cout[0]), 32'h1800);

    for (int i = 0; i < 4; i++) begin
      at_pos();
      chk($sformatf("lda_cw%0d", i + 1), 32'(a_cout[0]), 32'(lda_w[i]));
      if (i == 2) chk("ts4_forced", 32'(a_done[2]), 32'd1);
      if (i == 3) begin
        chk("ts4_wrap", 32'(a_ts[2]), 32'd1);
        chk("ts8_done", 32'(a_done[1]), 32'd1);
      end
    end
    chk("lda_done", 32'(a_done[0]), 32'd1);
    at_pos();
    chk("lda_wrap", 32'(a_ts[0]), 32'd1);
    chk("lda_wrap_cw", 32'(a_cout[0]), 32'h1800);

    opc = 4'h7; cf = 1'b1;
    at_pos(); at_pos(); at_pos();
    chk("jc_taken", 32'(a_cout[0]), 32'h0102);
    at_pos();
    cf = 1'b0;
    at_pos(); at_pos(); at_pos();
    chk("jc_not", 32'(a_cout[0]), 32'd0);
    chk("jc_done", 32'(a_done[0]), 32'd1);
    at_pos();
    chk("jc_next", 32'(a_ts[0]), 32'd1);

    opc = 4'h2;
    at_pos(); at_pos(); at_pos(); at_pos();
    chk("add_t4", 32'(a_cout[0]), 32'h0408);
    rst = 1'b1;
    #1;
    chk("rst_mid", 32'(a_cout[0]), 32'd0);
    chk("rst_mid_ts", 32'(a_ts[0]), 32'd0);
    at_pos();
    rst = 1'b0;
    #1;
    chk("rst_rel", 32'(a_cout[0]), 32'h1800);

    opc = 4'hF;
    at_pos(); at_pos(); at_pos();
    chk("hlt_pre", 32'(a_hlt[0]), 32'd0);
    at_pos();
    chk("hlt_set", 32'(a_hlt[0]), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      at_pos();
      chk("hlt_frozen", 32'({a_cout[0], a_ts[0]}), 32'd0);
    end
    rst = 1'b1; step = 1'b0;
    at_pos();
    chk("hlt_rst", 32'(a_hlt[0]), 32'd0);
    rst = 1'b0;

    opc = 4'hE; step_mode = 1'b1;
    at_pos(); at_pos(); at_pos();
    chk("out_cw", 32'(a_cout[0]), 32'h0044);
    at_pos();
    for (int i = 0; i < 10; i++) begin
      chk("wait_idle", 32'({a_cout[0], a_ts[0]}), 32'd0);
      at_pos();
    end
    step = 1'b1;
    at_pos();
    chk("step_go", 32'(a_ts[0]), 32'd1);
    at_pos(); at_pos(); at_pos(); at_pos();
    for (int i = 0; i < 5; i++) begin
      chk("step_held", 32'(a_ts[0]), 32'd0);
      at_pos();
    end
    step = 1'b0;
    at_pos();
    chk("step_low_wait", 32'(a_ts[0]), 32'd0);
    step_mode = 1'b0;
    at_pos();
    chk("mode_exit", 32'(a_ts[0]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 3) begin
        opc = 4'($urandom_range(0, 15));
        if (opc == 4'hF && $urandom_range(0, 3) != 0) opc = 4'hE;
      end
      cf = 1'($urandom);
      zf = 1'($urandom);
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
    end
    at_pos();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
